// File: rtl/seq_detector_param.sv
// seq_detector_param: serial PATTERN detector with KMP transitions built at elaboration,
// Mealy/Moore output timing, overlap control and a saturating match counter.
module seq_detector_param #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit           OVERLAP = 1'b1,
  parameter bit           MOORE   = 1'b0,
  parameter int           CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       x_in,
  output logic                       y_out,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(N+1)-1:0]     state_o
);
  localparam int SW   = $clog2(N+1);
  localparam int NS   = 2 ** SW;
  localparam int LAST = MOORE ? N : N - 1;
  // Longest PATTERN prefix that is a suffix of (first k pattern bits + b); N means a match.
  function automatic int step(input int k, input int b);
    logic [16:0] s;
    int r;
    bit ok;
    s = '0;
    r = 0;
    for (int i = 0; i < k; i++) s[i] = PATTERN[N-1-i];
    s[k] = b[0];
    for (int j = 1; j <= k + 1; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++) if (s[k+1-j+t] != PATTERN[N-1-t]) ok = 1'b0;
      if (ok) r = j;
    end
    return r;
  endfunction
  function automatic int fail_len();
    int r;
    bit ok;
    r = 0;
    for (int j = 1; j < N; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++) if (PATTERN[N-1-t] != PATTERN[j-1-t]) ok = 1'b0;
      if (ok) r = j;
    end
    return r;
  endfunction
  localparam int FN = fail_len();
  logic [SW-1:0]   state, state_nx;
  logic [SW-1:0]   tbl [2*NS];
  logic [2*NS-1:0] hit;
  logic [SW:0]     idx;
  logic            match;
  // Every encoding gets an entry; encodings beyond the last legal state fall back to 0.
  for (genvar k = 0; k < NS; k++) begin : g_k
    for (genvar b = 0; b < 2; b++) begin : g_b
      localparam int SRC = (k >= N) ? (OVERLAP ? FN : 0) : k;
      localparam int D   = step(SRC, b);
      localparam int T   = (k > LAST) ? 0 : (D < N) ? D : (MOORE ? N : (OVERLAP ? FN : 0));
      assign tbl[2*k+b] = SW'(T);
      assign hit[2*k+b] = (k <= LAST) && (D == N);
    end
  end
  assign idx     = {state, x_in};
  assign state_o = state;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= '0;
    else state <= state_nx;
  always_comb begin
    match    = en & hit[idx];
    state_nx = clr ? '0 : en ? tbl[idx] : state;
  end
  always_comb y_out = MOORE ? (state == SW'(N)) : match;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) match_cnt <= '0;
    else if (clr) match_cnt <= '0;
    else if (match && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: four detector configurations share one directed stream;
// the driver queues hand-computed expectations, a monitor pops and compares them.
module tb_seq_detector_param;
  logic clk, rstn, en, clr, x_in;
  logic       y0, y1, y2, y3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;
  logic [2:0] s0, s1, s2, s3;
  int tests = 0, failed = 0;
  typedef struct packed {
    logic [3:0]  y;
    logic [11:0] s;
    logic [25:0] c;
  } exp_t;
  exp_t sb[$];
  logic pb [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int   sm0 [4] = '{1, 2, 3, 1};
  int   sm1 [4] = '{1, 2, 3, 0};
  int   sm2 [4] = '{1, 2, 3, 4};

  seq_detector_param d0 (.clk(clk), .rstn(rstn), .en(en), .clr(clr), .x_in(x_in), .y_out(y0), .match_cnt(c0), .state_o(s0));
  seq_detector_param #(.OVERLAP(1'b0)) d1 (.clk(clk), .rstn(rstn), .en(en), .clr(clr), .x_in(x_in), .y_out(y1), .match_cnt(c1), .state_o(s1));
  seq_detector_param #(.MOORE(1'b1)) d2 (.clk(clk), .rstn(rstn), .en(en), .clr(clr), .x_in(x_in), .y_out(y2), .match_cnt(c2), .state_o(s2));
  seq_detector_param #(.OVERLAP(1'b0), .CNT_W(2)) d3 (.clk(clk), .rstn(rstn), .en(en), .clr(clr), .x_in(x_in), .y_out(y3), .match_cnt(c3), .state_o(s3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic vec(input logic e, input logic c, input logic x, input logic [3:0] y,
                     input int e0, input int e1, input int e2, input int e3,
                     input int k0, input int k1, input int k2, input int k3);
    exp_t t;
    @(negedge clk);
    en = e; clr = c; x_in = x;
    t.y = y;
    t.s = {3'(e3), 3'(e2), 3'(e1), 3'(e0)};
    t.c = {2'(k3), 8'(k2), 8'(k1), 8'(k0)};
    sb.push_back(t);
  endtask

  // Monitor: y just before the edge, state and count just after it.
  initial begin
    exp_t t;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        t = sb.pop_front();
        chk("y_out", 32'({y3, y2, y1, y0}), 32'(t.y));
        @(posedge clk);
        #1;
        chk("state_o", 32'({s3, s2, s1, s0}), 32'(t.s));
        chk("match_cnt", 32'({c3, c2, c1, c0}), 32'(t.c));
      end
    end
  end

  initial begin
    int cc;
    rstn = 1'b0; en = 1'b0; clr = 1'b0; x_in = 1'b0;
    #3;
    chk("reset_state", 32'({s3, s2, s1, s0}), 32'd0);
    chk("reset_cnt", 32'({c3, c2, c1, c0}), 32'd0);
    chk("reset_y", 32'({y3, y2, y1, y0}), 32'd0);
    #9 rstn = 1'b1;
    // stream 1,0,1,1,0,1,1
    vec(1, 0, 1, 4'b0000, 1, 1, 1, 1, 0, 0, 0, 0);
    vec(1, 0, 0, 4'b0000, 2, 2, 2, 2, 0, 0, 0, 0);
    vec(1, 0, 1, 4'b0000, 3, 3, 3, 3, 0, 0, 0, 0);
    vec(1, 0, 1, 4'b1011, 1, 0, 4, 0, 1, 1, 1, 1);
    vec(1, 0, 0, 4'b0100, 2, 0, 2, 0, 1, 1, 1, 1);
    vec(1, 0, 1, 4'b0000, 3, 1, 3, 1, 1, 1, 1, 1);
    vec(1, 0, 1, 4'b0001, 1, 1, 4, 1, 2, 1, 2, 1);
    vec(0, 1, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0);
    // stall with en=0 while x toggles
    vec(1, 0, 1, 4'b0000, 1, 1, 1, 1, 0, 0, 0, 0);
    vec(1, 0, 0, 4'b0000, 2, 2, 2, 2, 0, 0, 0, 0);
    vec(1, 0, 1, 4'b0000, 3, 3, 3, 3, 0, 0, 0, 0);
    vec(0, 0, 1, 4'b0000, 3, 3, 3, 3, 0, 0, 0, 0);
    vec(0, 0, 0, 4'b0000, 3, 3, 3, 3, 0, 0, 0, 0);
    vec(0, 0, 1, 4'b0000, 3, 3, 3, 3, 0, 0, 0, 0);
    vec(1, 0, 1, 4'b1011, 1, 0, 4, 0, 1, 1, 1, 1);
    vec(0, 0, 0, 4'b0100, 1, 0, 4, 0, 1, 1, 1, 1);
    vec(0, 0, 1, 4'b0100, 1, 0, 4, 0, 1, 1, 1, 1);
    vec(1, 1, 1, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0);
    // async reset mid-sequence
    vec(1, 0, 1, 4'b0000, 1, 1, 1, 1, 0, 0, 0, 0);
    vec(1, 0, 0, 4'b0000, 2, 2, 2, 2, 0, 0, 0, 0);
    vec(1, 0, 1, 4'b0000, 3, 3, 3, 3, 0, 0, 0, 0);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("async_rst_state", 32'({s3, s2, s1, s0}), 32'd0);
    chk("async_rst_cnt", 32'({c3, c2, c1, c0}), 32'd0);
    chk("async_rst_y", 32'({y3, y2, y1, y0}), 32'd0);
    rstn = 1'b1;
    vec(1, 0, 1, 4'b0000, 1, 1, 1, 1, 0, 0, 0, 0);
    // clr mid-sequence, then clr on a completing bit
    vec(1, 0, 0, 4'b0000, 2, 2, 2, 2, 0, 0, 0, 0);
    vec(1, 0, 1, 4'b0000, 3, 3, 3, 3, 0, 0, 0, 0);
    vec(1, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    vec(1, 0, 1, 4'b0000, 1, 1, 1, 1, 0, 0, 0, 0);
    vec(1, 0, 0, 4'b0000, 2, 2, 2, 2, 0, 0, 0, 0);
    vec(1, 0, 1, 4'b0000, 3, 3, 3, 3, 0, 0, 0, 0);
    vec(1, 1, 1, 4'b1011, 0, 0, 0, 0, 0, 0, 0, 0);
    // 1011 five times: counters run 1..5, the 2-bit one saturates at 3
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 4; i++) begin
        cc = (i == 3) ? r + 1 : r;
        vec(1, 0, pb[i], (i == 3) ? 4'b1011 : (i == 0 && r > 0) ? 4'b0100 : 4'b0000,
            sm0[i], sm1[i], sm2[i], sm1[i], cc, cc, cc, (cc > 3) ? 3 : cc);
      end
    vec(0, 0, 0, 4'b0100, 1, 0, 4, 0, 5, 5, 5, 3);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
